axi_lite_slave_driver: RTL and testbench

//  Synthesizable AXI4-Lite master that programs the NPU controller's configuration slave (top_main s00_axi).

---
 rtl/axil_drv_pkg.sv | 56 +++++
 rtl/axil_drv_wr_beat.sv | 105 ++++++++++
 rtl/axi_lite_slave_driver.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_lite_slave_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_drv_pkg.sv
// Shared definitions for the NPU controller AXI-Lite configuration driver:
// register offsets, mode encodings, command/state enums and the beat address map.
package axil_drv_pkg;

  localparam logic [7:0] REG_MODE       = 8'h00;
  localparam logic [7:0] REG_WL_START   = 8'h04;
  localparam logic [7:0] REG_WL_END     = 8'h08;
  localparam logic [7:0] REG_BL_START   = 8'h0C;
  localparam logic [7:0] REG_BL_END     = 8'h10;
  localparam logic [7:0] REG_ROUND      = 8'h14;
  localparam logic [7:0] REG_Q_INTERVAL = 8'h18;
  localparam logic [7:0] REG_Q_DEDUCT   = 8'h1C;
  localparam logic [7:0] REG_START      = 8'h20;

  localparam int MODE_SETRESET = 1;
  localparam int MODE_VMM      = MODE_SETRESET + 1;
  localparam int MODE_READ     = MODE_VMM + 1;

  localparam int NBEATS_Q    = 2;
  localparam int NBEATS_ARGS = 7;

  typedef enum logic {
    CMD_Q    = 1'b0,
    CMD_ARGS = 1'b1
  } cmd_type_e;

`ifdef AXIL_DRV_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR, S_WRESP, S_DONE, S_RD, S_RRESP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR, S_WRESP, S_DONE
  } state_e;
`endif

  // Register targeted by beat idx of a command; the ARGS burst ends with the START kick.
  function automatic logic [7:0] beat_offset(input cmd_type_e c, input logic [2:0] idx);
    logic [7:0] off;
    if (c == CMD_Q) begin
      off = (idx == 3'd0) ? REG_Q_INTERVAL : REG_Q_DEDUCT;
    end else begin
      case (idx)
        3'd0:    off = REG_MODE;
        3'd1:    off = REG_WL_START;
        3'd2:    off = REG_WL_END;
        3'd3:    off = REG_BL_START;
        3'd4:    off = REG_BL_END;
        3'd5:    off = REG_ROUND;
        default: off = REG_START;
      endcase
    end
    return off;
  endfunction

endpackage

// File: rtl/axil_drv_wr_beat.sv
// Single AXI-Lite write beat: AW and W raised together one cycle after start_i, each dropped after
// its own handshake; BREADY raised once both have completed and held until BVALID (done_o pulse).
module axil_drv_wr_beat #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  output logic            done_o,
  output logic [1:0]      bresp_o,
  output logic [AW-1:0]   awaddr_o,
  output logic [2:0]      awprot_o,
  output logic            awvalid_o,
  input  logic            awready_i,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wstrb_o,
  output logic            wvalid_o,
  input  logic            wready_i,
  input  logic [1:0]      bresp_i,
  input  logic            bvalid_i,
  output logic            bready_o
);

  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          aw_ok_q, aw_ok_d;
  logic          w_ok_q, w_ok_d;
  logic          bready_q, bready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic aw_hs, w_hs, b_hs;
  assign aw_hs = awvalid_q & awready_i;
  assign w_hs  = wvalid_q & wready_i;
  assign b_hs  = bready_q & bvalid_i;

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    bready_d  = bready_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (start_i) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_ok_d   = 1'b0;
      w_ok_d    = 1'b0;
      bready_d  = 1'b0;
      addr_d    = addr_i;
      data_d    = data_i;
    end else begin
      if (aw_hs) begin
        awvalid_d = 1'b0;
        aw_ok_d   = 1'b1;
      end
      if (w_hs) begin
        wvalid_d = 1'b0;
        w_ok_d   = 1'b1;
      end
      if (b_hs) begin
        bready_d = 1'b0;
        aw_ok_d  = 1'b0;
        w_ok_d   = 1'b0;
      end else if (!bready_q && aw_ok_d && w_ok_d) begin
        bready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      bready_q  <= bready_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign done_o    = b_hs;
  assign bresp_o   = bresp_i;
  assign awaddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = data_q;
  assign wstrb_o   = '1;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

endmodule

// File: rtl/axi_lite_slave_driver.sv
// AXI-Lite master that expands one sequencer command into a burst of single-beat register writes;
// cmd_ready only in IDLE, one write outstanding. AXIL_DRV_READBACK_EN adds read-back verification.
module axi_lite_slave_driver
  import axil_drv_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8,
  parameter int BATCH_SIZE_VMM     = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_type,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   q_interval,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   q_deduct,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wl_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wl_end,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   bl_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   bl_end,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   round,
  output logic                            busy,
  output logic                            done,
  output logic                            err_resp,
  output logic                            err_arg,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef struct packed {
    logic [DW-1:0] q_interval;
    logic [DW-1:0] q_deduct;
    logic [DW-1:0] mode;
    logic [DW-1:0] wl_start;
    logic [DW-1:0] wl_end;
    logic [DW-1:0] bl_start;
    logic [DW-1:0] bl_end;
    logic [DW-1:0] round;
  } args_t;

  state_e    state_q, state_d;
  cmd_type_e cmd_q, cmd_d;
  args_t     args_q, args_d;
  logic [2:0] idx_q, idx_d;
  logic      err_resp_q, err_resp_d;
  logic      err_arg_q, err_arg_d;

  logic          beat_start, beat_done;
  logic [1:0]    beat_bresp;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_data;
  logic          args_ok, last_beat;

  assign beat_addr = AW'(beat_offset(cmd_q, idx_q));
  assign last_beat = (cmd_q == CMD_Q) ? (idx_q == 3'(NBEATS_Q - 1))
                                      : (idx_q == 3'(NBEATS_ARGS - 1));
  assign args_ok = (args_q.mode >= DW'(MODE_SETRESET)) && (args_q.mode <= DW'(MODE_READ)) &&
                   (args_q.wl_end > args_q.wl_start) && (args_q.bl_end > args_q.bl_start) &&
                   (args_q.round < DW'(BATCH_SIZE_VMM));

  always_comb begin
    beat_data = '0;
    if (cmd_q == CMD_Q) begin
      beat_data = (idx_q == 3'd0) ? args_q.q_interval : args_q.q_deduct;
    end else begin
      case (idx_q)
        3'd0:    beat_data = args_q.mode;
        3'd1:    beat_data = args_q.wl_start;
        3'd2:    beat_data = args_q.wl_end;
        3'd3:    beat_data = args_q.bl_start;
        3'd4:    beat_data = args_q.bl_end;
        3'd5:    beat_data = args_q.round;
        default: beat_data = DW'(1);
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    args_d     = args_q;
    idx_d      = idx_q;
    err_resp_d = err_resp_q;
    err_arg_d  = err_arg_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_CHECK;
          cmd_d      = cmd_type_e'(cmd_type);
          args_d     = '{q_interval, q_deduct, mode, wl_start, wl_end, bl_start, bl_end, round};
          idx_d      = 3'd0;
          err_resp_d = 1'b0;
          err_arg_d  = 1'b0;
        end
      end
      S_CHECK: begin
        if (cmd_q == CMD_ARGS && !args_ok) begin
          err_arg_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: state_d = S_WRESP;
      S_WRESP: begin
        if (beat_done) begin
          if (beat_bresp != 2'b00) begin
            err_resp_d = 1'b1;
            state_d    = S_DONE;
`ifdef AXIL_DRV_READBACK_EN
          end else if (!(cmd_q == CMD_ARGS && last_beat)) begin
            state_d = S_RD;
`endif
          end else if (last_beat) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_WR;
          end
        end
      end
`ifdef AXIL_DRV_READBACK_EN
      S_RD: if (M_AXI_ARREADY) state_d = S_RRESP;
      S_RRESP: begin
        // Read-back must echo exactly what was just written.
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != beat_data) begin
            err_resp_d = 1'b1;
            state_d    = S_DONE;
          end else if (last_beat) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_WR;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cmd_q      <= CMD_Q;
      args_q     <= '0;
      idx_q      <= 3'd0;
      err_resp_q <= 1'b0;
      err_arg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      args_q     <= args_d;
      idx_q      <= idx_d;
      err_resp_q <= err_resp_d;
      err_arg_q  <= err_arg_d;
    end
  end

  assign beat_start = (state_q == S_WR);

  axil_drv_wr_beat #(.DW(DW), .AW(AW)) u_wr_beat (
    .clk       (clk),
    .reset     (reset),
    .start_i   (beat_start),
    .addr_i    (beat_addr),
    .data_i    (beat_data),
    .done_o    (beat_done),
    .bresp_o   (beat_bresp),
    .awaddr_o  (M_AXI_AWADDR),
    .awprot_o  (M_AXI_AWPROT),
    .awvalid_o (M_AXI_AWVALID),
    .awready_i (M_AXI_AWREADY),
    .wdata_o   (M_AXI_WDATA),
    .wstrb_o   (M_AXI_WSTRB),
    .wvalid_o  (M_AXI_WVALID),
    .wready_i  (M_AXI_WREADY),
    .bresp_i   (M_AXI_BRESP),
    .bvalid_i  (M_AXI_BVALID),
    .bready_o  (M_AXI_BREADY)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err_resp  = err_resp_q;
  assign err_arg   = err_arg_q;

`ifdef AXIL_DRV_READBACK_EN
  assign M_AXI_ARVALID = (state_q == S_RD);
  assign M_AXI_ARADDR  = M_AXI_ARVALID ? beat_addr : '0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == S_RRESP);
`else
  logic unused_rd;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_slave_driver.sv
// Directed bench: reactive AXI-Lite slave with programmable AW delay and error beat,
// logs every write handshake and compares against hand-computed register sequences.
module tb_axi_lite_slave_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_type = 1'b0;
  logic [31:0] q_interval = '0, q_deduct = '0, mode = '0;
  logic [31:0] wl_start = '0, wl_end = '0, bl_start = '0, bl_end = '0, round = '0;
  logic        cmd_ready, busy, done, err_resp, err_arg;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;

  axi_lite_slave_driver dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .q_interval(q_interval), .q_deduct(q_deduct), .mode(mode),
    .wl_start(wl_start), .wl_end(wl_end), .bl_start(bl_start), .bl_end(bl_end), .round(round),
    .busy(busy), .done(done), .err_resp(err_resp), .err_arg(err_arg),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus only)
  int aw_delay = 0;
  int err_beat = 99;

  // Slave/monitor state (written by the negedge process only)
  logic [7:0]  aw_log [16];
  logic [31:0] w_log [16];
  int aw_n = 0, w_n = 0, done_n = 0, beat_n = 0, aw_wait = 0, aw_cyc = 0;
  bit aw_got = 0, w_got = 0, b_fire = 0, busy_prev = 0, awv_prev = 0, wv_prev = 0;
  bit w_early = 0, bready_early = 0, busy_gap = 0, rise_bad = 0, prot_bad = 0;

  always @(negedge clk) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      aw_got = 0; w_got = 0; b_fire = 0; aw_wait = 0; beat_n = 0;
      busy_prev = 0; awv_prev = 0; wv_prev = 0;
    end else begin
      if (busy && !busy_prev) begin
        aw_n = 0; w_n = 0; done_n = 0; beat_n = 0; aw_cyc = 0;
        w_early = 0; bready_early = 0; busy_gap = 0; rise_bad = 0; prot_bad = 0;
      end
      if (busy_prev && !busy && done_n == 0) busy_gap = 1;
      busy_prev = busy;
      if (done) done_n++;
      if (awvalid) aw_cyc++;
      if (awvalid && !wvalid) w_early = 1;
      if (bready && (awvalid || wvalid)) bready_early = 1;
      if ((awvalid && !awv_prev) != (wvalid && !wv_prev)) rise_bad = 1;
      if (awvalid && (awprot != 3'b000 || wstrb != 4'hF)) prot_bad = 1;
      awv_prev = awvalid;
      wv_prev  = wvalid;
      // Write response channel
      if (b_fire) begin
        bvalid = 0; b_fire = 0; beat_n++;
      end else begin
        if (!bvalid && aw_got && w_got) begin
          bvalid = 1;
          bresp  = (beat_n == err_beat) ? 2'b10 : 2'b00;
          aw_got = 0; w_got = 0;
        end
        if (bvalid && bready) b_fire = 1;
      end
      // Address and data channels: a ready chosen here completes at the next posedge
      awready = 0;
      if (awvalid) begin
        if (aw_wait >= aw_delay) begin
          awready = 1; aw_got = 1; aw_wait = 0;
          if (aw_n < 16) aw_log[aw_n] = awaddr;
          aw_n++;
        end else begin
          aw_wait++;
        end
      end
      wready = 0;
      if (wvalid) begin
        wready = 1; w_got = 1;
        if (w_n < 16) w_log[w_n] = wdata;
        w_n++;
      end
    end
  end

  task automatic issue(input bit t, input logic [31:0] m, a, b, c, d, r, qi, qd);
    @(negedge clk);
    cmd_type = t; mode = m; wl_start = a; wl_end = b; bl_start = c; bl_end = d; round = r;
    q_interval = qi; q_deduct = qd; cmd_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs so only latched values can reach the bus
    cmd_valid = 1'b0; cmd_type = ~t; mode = '1; wl_start = '1; wl_end = '0;
    bl_start = '1; bl_end = '0; round = '1; q_interval = 32'h5A5A5A5A; q_deduct = 32'hA5A5A5A5;
  endtask

  task automatic wait_done(input string tag);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_args(input string tag);
    logic [7:0]  ea [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20};
    logic [31:0] ed [7] = '{32'd3, 32'd0, 32'd32, 32'd0, 32'd10, 32'd0, 32'd1};
    check({tag, "_aw_n"}, aw_n, 7);
    check({tag, "_w_n"}, w_n, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s_addr%0d", tag, i), {24'd0, aw_log[i]}, {24'd0, ea[i]});
      check($sformatf("%s_data%0d", tag, i), w_log[i], ed[i]);
    end
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_busy_gap"}, 32'(busy_gap), 0);
    check({tag, "_rise"}, 32'(rise_bad), 0);
    check({tag, "_prot"}, 32'(prot_bad), 0);
    check({tag, "_err"}, {30'd0, err_resp, err_arg}, 0);
  endtask

  task automatic check_q(input string tag);
    check({tag, "_aw_n"}, aw_n, 2);
    check({tag, "_addr0"}, {24'd0, aw_log[0]}, 32'h18);
    check({tag, "_data0"}, w_log[0], 32'h326);
    check({tag, "_addr1"}, {24'd0, aw_log[1]}, 32'h1C);
    check({tag, "_data1"}, w_log[1], 32'h0);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_err"}, {30'd0, err_resp, err_arg}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    check("rst_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_awaddr", {24'd0, awaddr}, 0);
    check("rst_wdata", wdata, 0);
    check("rst_araddr", {24'd0, araddr}, 0);
    check("rst_err", {30'd0, err_resp, err_arg}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(1'b0, 0, 0, 0, 0, 0, 0, 32'd806, 32'd0);
    wait_done("q");
    check_q("q");

    issue(1'b1, 3, 0, 32, 0, 10, 0, 0, 0);
    wait_done("args");
    check_args("args");
    check("args_bready_early", 32'(bready_early), 0);

    aw_delay = 3;
    issue(1'b1, 3, 0, 32, 0, 10, 0, 0, 0);
    wait_done("slow");
    check_args("slow");
    check("slow_w_first", 32'(w_early), 1);
    check("slow_bready_early", 32'(bready_early), 0);
    check("slow_aw_cycles", aw_cyc, 7 * 4);
    aw_delay = 0;

    issue(1'b1, 3, 0, 32, 0, 10, 2, 0, 0);
    wait_done("bad_round");
    check("bad_round_aw", aw_cyc, 0);
    check("bad_round_err_arg", 32'(err_arg), 1);
    check("bad_round_done_n", done_n, 1);

    issue(1'b1, 2, 5, 5, 0, 10, 1, 0, 0);
    wait_done("bad_wl");
    check("bad_wl_aw", aw_cyc, 0);
    check("bad_wl_err_arg", 32'(err_arg), 1);
    check("bad_wl_done_n", done_n, 1);

    issue(1'b0, 0, 0, 0, 0, 0, 0, 32'd806, 32'd0);
    wait_done("clr_arg");
    check_q("clr_arg");

    err_beat = 2;
    issue(1'b1, 3, 0, 32, 0, 10, 0, 0, 0);
    wait_done("bresp");
    check("bresp_aw_n", aw_n, 3);
    check("bresp_err_resp", 32'(err_resp), 1);
    check("bresp_done_n", done_n, 1);
    err_beat = 99;

    issue(1'b0, 0, 0, 0, 0, 0, 0, 32'd806, 32'd0);
    wait_done("clr_resp");
    check_q("clr_resp");

    begin
      bit hit = 0;
      issue(1'b1, 3, 0, 32, 0, 10, 0, 0, 0);
      for (int i = 0; i < 300 && !hit; i++) begin
        if (awvalid && awaddr == 8'h0C) hit = 1;
        else @(negedge clk);
      end
      check("rst_mid_beat4_seen", 32'(hit), 1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_valids", {29'd0, awvalid, wvalid, bready}, 0);
      check("rst_mid_ready_busy", {30'd0, cmd_ready, busy}, 32'b10);
      check("rst_mid_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mid_no_done", done_n, 0);
      check("rst_mid_idle", {30'd0, cmd_ready, busy}, 32'b10);
    end

    issue(1'b0, 0, 0, 0, 0, 0, 0, 32'd806, 32'd0);
    wait_done("post_rst");
    check_q("post_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
